// File: rtl/ccff_loader.sv
// ccff_loader: serialises configuration words MSB-first into the ccff chain,
// then optionally recirculates the chain through ccff_tail and compares a
// CRC-16 of the returned bits with the CRC of the loaded bits.
module ccff_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 40,
    parameter int VERIFY_EN = 1
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam int REM_W  = $clog2(CHAIN_LEN + 1);

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;      // bits left in the current word
    logic [REM_W-1:0]  rem_q, rem_d;        // chain bits left to load / verify
    logic [WORD_W-1:0] sreg_q, sreg_d;      // word being shifted out, MSB first
    logic [15:0]       crc_ld_q, crc_ld_d;  // CRC over the loaded bits
    logic [15:0]       crc_vf_q, crc_vf_d;  // CRC over the bits returned on ccff_tail
    logic              crc_err_q, crc_err_d;

    logic              in_load;
    logic              load_shift;
    logic              load_hs;
    logic [31:0]       rem_after;
    logic [BCNT_W-1:0] next_word_bits;

    // One bit-serial step of CRC-16/0x1021, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    // Load-phase handshake and word-length bookkeeping. The next word is
    // requested while the last bit of the current one is on the chain, so a
    // continuously valid stream produces no bubbles.
    always_comb begin
        in_load        = (state_q == ST_LOAD);
        load_shift     = in_load && (bcnt_q != '0);
        bs_ready       = in_load && (bcnt_q <= BCNT_W'(1)) && (32'(rem_q) > 32'(bcnt_q));
        load_hs        = bs_ready && bs_valid;
        // Chain bits still owed once this cycle's shift (if any) has happened.
        rem_after      = 32'(rem_q) - 32'(bcnt_q);
        // A final short word only contributes its top bits; the LSBs are dropped.
        next_word_bits = (rem_after >= 32'(WORD_W)) ? BCNT_W'(WORD_W) : BCNT_W'(rem_after);
    end

    // Next-state logic for the sequencer, counters, shift register and CRCs.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        rem_d     = rem_q;
        sreg_d    = sreg_q;
        crc_ld_d  = crc_ld_q;
        crc_vf_d  = crc_vf_q;
        crc_err_d = crc_err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    rem_d     = REM_W'(CHAIN_LEN);
                    bcnt_d    = '0;
                    crc_ld_d  = CRC_INIT;
                    crc_vf_d  = CRC_INIT;
                    crc_err_d = 1'b0;
                end
            end

            ST_LOAD: begin
                if (load_hs) begin
                    sreg_d = bs_data;
                    bcnt_d = next_word_bits;
                end else if (load_shift) begin
                    sreg_d = sreg_q << 1;
                    bcnt_d = bcnt_q - BCNT_W'(1);
                end

                if (load_shift) begin
                    rem_d    = rem_q - REM_W'(1);
                    crc_ld_d = crc16_step(crc_ld_q, sreg_q[WORD_W-1]);
                    if (rem_q == REM_W'(1)) begin
                        if (VERIFY_EN != 0) begin
                            state_d = ST_VERIFY;
                            rem_d   = REM_W'(CHAIN_LEN);
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_VERIFY: begin
                crc_vf_d = crc16_step(crc_vf_q, ccff_tail);
                rem_d    = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    state_d   = ST_DONE;
                    // Compare with the CRC that includes this final returned bit.
                    crc_err_d = (crc_vf_d != crc_ld_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Chain drive: registered bit in LOAD, tail looped straight back in VERIFY
    // so that CHAIN_LEN verify shifts leave the configuration intact.
    always_comb begin
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ccff_head     = sreg_q[WORD_W-1];
                ccff_shift_en = (bcnt_q != '0);
            end
            ST_VERIFY: begin
                ccff_head     = ccff_tail;
                ccff_shift_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    assign done    = (state_q == ST_DONE);
    assign crc_err = crc_err_q;

    // State registers; reset takes effect immediately, even mid-load.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= '0;
            rem_q     <= '0;
            sreg_q    <= '0;
            crc_ld_q  <= CRC_INIT;
            crc_vf_q  <= CRC_INIT;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            rem_q     <= rem_d;
            sreg_q    <= sreg_d;
            crc_ld_q  <= crc_ld_d;
            crc_vf_q  <= crc_vf_d;
            crc_err_q <= crc_err_d;
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Testbench for ccff_loader: three instances (40-bit chain with verify,
// 64-bit chain with verify, 40-bit chain without verify) share one clock and
// reset; a shift-register chain model closes the loop for the selected one.
module tb_ccff_loader;

    localparam int W        = 32;
    localparam int FLIP_CYC = 50;

    typedef struct packed {
        int   cyc;
        logic vf;
        logic val;
    } sh_ev_t;

    typedef struct packed {
        int   cyc;
        logic err;
    } done_ev_t;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic [2:0]   start_v = '0;
    logic [2:0]   valid_v = '0;
    logic [W-1:0] bs_data = '0;
    logic [2:0]   tail_v;
    logic [2:0]   ready_v, head_v, sh_v, busy_v, done_v, err_v;

    int           tick    = 0;
    int           t0      = 0;
    int           sel     = 0;
    int           cur_len = 40;
    logic         corrupt = 1'b0;
    logic         mon_en  = 1'b0;
    logic [63:0]  chain   = '0;
    logic         tail_bit;

    logic m_head, m_sh, m_valid, m_ready, m_done, m_err, m_tail;

    sh_ev_t   sh_q[$];
    int       hs_q[$];
    done_ev_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(40), .VERIFY_EN(1)) u_dut0 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_v[0]), .bs_valid(valid_v[0]),
        .bs_data(bs_data), .bs_ready(ready_v[0]), .ccff_tail(tail_v[0]), .ccff_head(head_v[0]),
        .ccff_shift_en(sh_v[0]), .busy(busy_v[0]), .done(done_v[0]), .crc_err(err_v[0])
    );

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(64), .VERIFY_EN(1)) u_dut1 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_v[1]), .bs_valid(valid_v[1]),
        .bs_data(bs_data), .bs_ready(ready_v[1]), .ccff_tail(tail_v[1]), .ccff_head(head_v[1]),
        .ccff_shift_en(sh_v[1]), .busy(busy_v[1]), .done(done_v[1]), .crc_err(err_v[1])
    );

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(40), .VERIFY_EN(0)) u_dut2 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_v[2]), .bs_valid(valid_v[2]),
        .bs_data(bs_data), .bs_ready(ready_v[2]), .ccff_tail(tail_v[2]), .ccff_head(head_v[2]),
        .ccff_shift_en(sh_v[2]), .busy(busy_v[2]), .done(done_v[2]), .crc_err(err_v[2])
    );

    assign m_head  = head_v[sel];
    assign m_sh    = sh_v[sel];
    assign m_valid = valid_v[sel];
    assign m_ready = ready_v[sel];
    assign m_done  = done_v[sel];
    assign m_err   = err_v[sel];
    assign m_tail  = tail_v[sel];

    // Chain model: last memory drives ccff_tail; one bit can be flipped on the way back.
    assign tail_bit = chain[6'(cur_len - 1)] ^ (corrupt && ((tick - t0) == FLIP_CYC));
    assign tail_v   = tail_bit ? (3'b001 << sel) : 3'b000;

    always @(posedge clk) begin
        if (m_sh) chain <= {chain[62:0], m_head};
    end

    task automatic note(input bit ok, input string msg);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s", msg);
        end
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT shifts, handshakes or finishes.
    int       mon_rel;
    sh_ev_t   mon_se;
    done_ev_t mon_de;
    int       mon_hc;
    logic     mon_want;
    logic     done_prev = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_rel = tick - t0;
            if (mon_en) begin
                if (m_sh) begin
                    if (sh_q.size() == 0) begin
                        note(1'b0, $sformatf("extra_shift: got shift at cycle %0d, want none", mon_rel));
                    end else begin
                        mon_se   = sh_q.pop_front();
                        mon_want = mon_se.vf ? m_tail : mon_se.val;
                        note((mon_rel == mon_se.cyc) && (m_head == mon_want),
                             $sformatf("%s: got cycle %0d head %0b, want cycle %0d head %0b",
                                       mon_se.vf ? "verify_bit" : "load_bit",
                                       mon_rel, m_head, mon_se.cyc, mon_want));
                    end
                end
                if (m_valid && m_ready) begin
                    $display("hs   : inst %0d word %08h accepted at cycle %0d", sel, bs_data, mon_rel);
                    if (hs_q.size() == 0) begin
                        note(1'b0, $sformatf("extra_handshake: got handshake at cycle %0d, want none", mon_rel));
                    end else begin
                        mon_hc = hs_q.pop_front();
                        note(mon_rel == mon_hc,
                             $sformatf("handshake: got cycle %0d, want cycle %0d", mon_rel, mon_hc));
                    end
                end
                if (m_done && !done_prev) begin
                    $display("done : inst %0d at cycle %0d crc_err %0b", sel, mon_rel, m_err);
                    if (done_q.size() == 0) begin
                        note(1'b0, $sformatf("extra_done: got done at cycle %0d, want none", mon_rel));
                    end else begin
                        mon_de = done_q.pop_front();
                        note((mon_rel == mon_de.cyc) && (m_err == mon_de.err),
                             $sformatf("done: got cycle %0d crc_err %0b, want cycle %0d crc_err %0b",
                                       mon_rel, m_err, mon_de.cyc, mon_de.err));
                    end
                end
            end
            done_prev = m_done;
        end
    end

    // One complete load (and verify) on instance inst. Called at posedge+1;
    // that cycle becomes cycle 0, the cycle in which start is sampled.
    task automatic run_test(input int inst, input int len, input bit ven,
                            input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input int offer1, input int hs0, input int hs1,
                            input int done_cyc, input bit corr, input int ign);
        logic [W-1:0] words [2];
        int           hs_exp [2];
        int           rem, n, g;
        bit           got;
        logic [63:0]  exp_chain, mask;
        sh_ev_t       se;
        done_ev_t     de;

        words[0]  = w0;
        words[1]  = w1;
        hs_exp[0] = hs0;
        hs_exp[1] = hs1;
        sel       = inst;
        cur_len   = len;
        corrupt   = corr;
        sh_q.delete();
        hs_q.delete();
        done_q.delete();

        // Expected handshakes and load bits: word accepted at h puts its bits at h+1, h+2, ...
        exp_chain = '0;
        rem       = len;
        for (int k = 0; k < 2; k++) begin
            n = (rem < W) ? rem : W;
            hs_q.push_back(hs_exp[k]);
            for (int i = 0; i < n; i++) begin
                se.cyc = hs_exp[k] + 1 + i;
                se.vf  = 1'b0;
                se.val = words[k][W-1-i];
                sh_q.push_back(se);
                exp_chain = {exp_chain[62:0], words[k][W-1-i]};
            end
            rem -= n;
        end
        if (ven) begin
            for (int i = 0; i < len; i++) begin
                se.cyc = done_cyc - len + i;
                se.vf  = 1'b1;
                se.val = 1'b0;
                sh_q.push_back(se);
            end
        end
        de.cyc = done_cyc;
        de.err = corr;
        done_q.push_back(de);
        mask   = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
        mon_en = 1'b1;

        t0 = tick;
        start_v[inst] = 1'b1;
        fork
            begin
                @(posedge clk); #1;
                start_v[inst] = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    valid_v[inst] = 1'b0;
                    while ((tick - t0) < ((k == 0) ? 1 : offer1)) begin
                        @(posedge clk); #1;
                    end
                    valid_v[inst] = 1'b1;
                    bs_data       = words[k];
                    got = 1'b0;
                    g   = 0;
                    while (!got && g < 300) begin
                        @(negedge clk);
                        got = valid_v[inst] && ready_v[inst];
                        @(posedge clk); #1;
                        g++;
                    end
                    if (!got) note(1'b0, $sformatf("handshake_timeout: word %0d not accepted, want cycle %0d", k, hs_exp[k]));
                end
                // Keep offering junk so that any extra bs_ready shows up as a handshake.
                bs_data = 32'h0BAD_F00D;
                g = 0;
                while (g < 400) begin
                    @(negedge clk);
                    if (done_v[inst]) break;
                    @(posedge clk); #1;
                    g++;
                end
                if (!done_v[inst]) note(1'b0, $sformatf("done_timeout: got done 0, want 1 by cycle %0d", done_cyc));
                @(posedge clk); #1;
                valid_v[inst] = 1'b0;
            end
            begin
                if (ign >= 0) begin
                    while ((tick - t0) < ign) begin
                        @(posedge clk); #1;
                    end
                    start_v[inst] = 1'b1;
                    @(posedge clk); #1;
                    start_v[inst] = 1'b0;
                end
            end
        join

        repeat (2) begin
            @(posedge clk); #1;
        end
        note((sh_q.size() == 0) && (hs_q.size() == 0) && (done_q.size() == 0),
             $sformatf("leftover_events: got %0d shifts %0d handshakes %0d dones pending, want 0",
                       sh_q.size(), hs_q.size(), done_q.size()));
        if (!corr) begin
            note((chain & mask) == exp_chain,
                 $sformatf("chain_contents: got %016h, want %016h", chain & mask, exp_chain));
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            note({ready_v[i], head_v[i], sh_v[i], busy_v[i], done_v[i], err_v[i]} == 6'b0,
                 $sformatf("reset_state inst %0d: got ready/head/sh/busy/done/err %06b, want 000000",
                           i, {ready_v[i], head_v[i], sh_v[i], busy_v[i], done_v[i], err_v[i]}));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal load; start pulse during VERIFY is ignored.
        run_test(0, 40, 1'b1, 32'hA5A5_0F0F, 32'hC3A1_B2C4, 0, 1, 33, 82, 1'b0, 60);
        // Stall: second word withheld until cycle 38.
        run_test(0, 40, 1'b1, 32'h5AF0_3C96, 32'h817E_00FF, 38, 1, 38, 87, 1'b0, -1);
        // Corrupted tail bit during VERIFY.
        run_test(0, 40, 1'b1, 32'hA5A5_0F0F, 32'hC3A1_B2C4, 0, 1, 33, 82, 1'b1, -1);

        // Reset in the middle of a load.
        mon_en  = 1'b0;
        sel     = 0;
        corrupt = 1'b0;
        t0      = tick;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        valid_v[0] = 1'b1;
        bs_data    = 32'hFFFF_FFFF;
        while ((tick - t0) < 20) begin
            @(posedge clk); #1;
        end
        note(busy_v[0] && sh_v[0], $sformatf("pre_reset_load: got busy %0b shift_en %0b, want 1 1", busy_v[0], sh_v[0]));
        rst_n = 1'b0;
        #1;
        note({ready_v[0], head_v[0], sh_v[0], busy_v[0], done_v[0], err_v[0]} == 6'b0,
             $sformatf("async_reset: got ready/head/sh/busy/done/err %06b, want 000000",
                       {ready_v[0], head_v[0], sh_v[0], busy_v[0], done_v[0], err_v[0]}));
        valid_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        note({ready_v[0], busy_v[0], done_v[0]} == 3'b0,
             $sformatf("idle_after_reset: got ready/busy/done %03b, want 000", {ready_v[0], busy_v[0], done_v[0]}));

        // Full reload after the reset.
        run_test(0, 40, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 0, 1, 33, 82, 1'b0, -1);
        // Chain length an exact multiple of the word width.
        run_test(1, 64, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 33, 130, 1'b0, -1);
        // No verify pass; start pulse during LOAD is ignored.
        run_test(2, 40, 1'b0, 32'hA5A5_0F0F, 32'hC3A1_B2C4, 0, 1, 33, 42, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1000000 time units, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
